rgb_fade_seq: RTL

//  Upstream colour sequencer for the RGB PWM LED path. Walks a fixed 8-entry palette and

---
 rtl/rgb_fade_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rgb_fade_seq.sv
// RGB colour fade sequencer.
// Steps through an 8-entry palette. Each channel's 8-bit duty ramps toward
// the current target colour by STEP once per tick. The reached colour is held
// for HOLD_TICKS ticks, and then the sequencer moves on to the next colour.
// Duty outputs drive the red/green/blue PWM channels downstream.
module rgb_fade_seq #(
  parameter int TICK_DIV   = 65536,
  parameter int STEP       = 8,
  parameter int HOLD_TICKS = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       step_req,
  output logic [7:0] red_duty,
  output logic [7:0] green_duty,
  output logic [7:0] blue_duty,
  output logic       duty_upd,
  output logic       pwm_en,
  output logic [2:0] color_idx
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int            HW        = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [7:0]    STEP_8    = 8'(STEP);

  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick_cnt, tick_cnt_nx;
  logic [HW-1:0] hold_cnt, hold_cnt_nx;
  logic [2:0]    idx_nx;
  logic [7:0]    red_nx, grn_nx, blu_nx;
  logic [7:0]    red_st, grn_st, blu_st;
  logic [23:0]   tgt;
  logic          upd_nx;
  logic          tick;

  // Move cur one STEP toward tgt. Land exactly on tgt when it is within
  // STEP, so the value never overshoots and never wraps past 0 or 255.
  function automatic logic [7:0] sat_step(input logic [7:0] cur, input logic [7:0] tgt_v);
    logic [8:0] diff;
    sat_step = cur;
    if (tgt_v > cur) begin
      diff = {1'b0, tgt_v} - {1'b0, cur};
      if (diff <= {1'b0, STEP_8}) sat_step = tgt_v;
      else                        sat_step = cur + STEP_8;
    end else if (tgt_v < cur) begin
      diff = {1'b0, cur} - {1'b0, tgt_v};
      if (diff <= {1'b0, STEP_8}) sat_step = tgt_v;
      else                        sat_step = cur - STEP_8;
    end
  endfunction

  // Palette lookup: {R, G, B}.
  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = {8'd255, 8'd0,   8'd0  };
      3'd1:    palette = {8'd255, 8'd255, 8'd0  };
      3'd2:    palette = {8'd0,   8'd255, 8'd0  };
      3'd3:    palette = {8'd0,   8'd255, 8'd255};
      3'd4:    palette = {8'd0,   8'd0,   8'd255};
      3'd5:    palette = {8'd255, 8'd0,   8'd255};
      3'd6:    palette = {8'd255, 8'd255, 8'd255};
      default: palette = {8'd0,   8'd0,   8'd0  };
    endcase
  endfunction

  assign tgt    = palette(color_idx);
  assign red_st = sat_step(red_duty,   tgt[23:16]);
  assign grn_st = sat_step(green_duty, tgt[15:8]);
  assign blu_st = sat_step(blue_duty,  tgt[7:0]);
  assign tick   = (state != IDLE) && (tick_cnt == TICK_LAST);

  // Next-state and next-datapath decode. Disable beats step_req, and
  // step_req beats a tick that arrives in the same cycle.
  always_comb begin
    state_nx    = state;
    idx_nx      = color_idx;
    hold_cnt_nx = hold_cnt;
    red_nx      = red_duty;
    grn_nx      = green_duty;
    blu_nx      = blue_duty;
    upd_nx      = 1'b0;
    if (!enable) begin
      state_nx    = IDLE;
      hold_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx    = FADE;
          hold_cnt_nx = '0;
        end
        FADE: begin
          if (step_req) begin
            idx_nx      = color_idx + 3'd1;
            hold_cnt_nx = '0;
          end else if (tick) begin
            red_nx = red_st;
            grn_nx = grn_st;
            blu_nx = blu_st;
            upd_nx = (red_st != red_duty) || (grn_st != green_duty) ||
                     (blu_st != blue_duty);
            if ({red_st, grn_st, blu_st} == tgt) begin
              state_nx    = HOLD;
              hold_cnt_nx = '0;
            end
          end
        end
        HOLD: begin
          if (step_req) begin
            idx_nx      = color_idx + 3'd1;
            state_nx    = FADE;
            hold_cnt_nx = '0;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              idx_nx      = color_idx + 3'd1;
              state_nx    = FADE;
              hold_cnt_nx = '0;
            end else begin
              hold_cnt_nx = hold_cnt + HW'(1);
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    // The tick divider only runs outside IDLE and restarts from zero whenever
    // the sequencer parks in IDLE.
    if (state == IDLE || state_nx == IDLE) tick_cnt_nx = '0;
    else if (tick_cnt == TICK_LAST)        tick_cnt_nx = '0;
    else                                   tick_cnt_nx = tick_cnt + TW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Counters, duties and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt   <= '0;
      hold_cnt   <= '0;
      color_idx  <= 3'd0;
      red_duty   <= 8'd0;
      green_duty <= 8'd0;
      blue_duty  <= 8'd0;
      duty_upd   <= 1'b0;
      pwm_en     <= 1'b0;
    end else begin
      tick_cnt   <= tick_cnt_nx;
      hold_cnt   <= hold_cnt_nx;
      color_idx  <= idx_nx;
      red_duty   <= red_nx;
      green_duty <= grn_nx;
      blue_duty  <= blu_nx;
      duty_upd   <= upd_nx;
      pwm_en     <= enable;
    end
  end

endmodule
